// File: rtl/adler_pkg.sv
// Shared definitions for the Adler-32 stream engine.
//   ADLER_MOD  : Adler-32 modulus (largest prime below 2^16)
//   ADLER_INIT : starting {B,A} for a fresh message
//   state_t    : engine state (ACCUM, DONE)
//   mod_sub    : reduce a 17-bit value already below 2*ADLER_MOD
package adler_pkg;

    localparam logic [15:0] ADLER_MOD  = 16'd65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    // Exact for any input below 2*ADLER_MOD, which every lane step and the
    // seed path guarantee, so one conditional subtract suffices.
    function automatic logic [15:0] mod_sub(input logic [16:0] x);
        logic [16:0] m;
        logic [16:0] d;
        m = {1'b0, ADLER_MOD};
        d = x - m;
        if (x >= m) begin
            return d[15:0];
        end
        return x[15:0];
    endfunction

endpackage

// File: rtl/adler_lane_step.sv
// One byte of Adler-32 folding, purely combinational.
//   a_in, b_in   : running sums entering this lane
//   byte_in      : data byte for this lane
//   keep         : lane carries a valid byte; when 0 the sums pass through
//   a_out, b_out : running sums leaving this lane
module adler_lane_step
    import adler_pkg::*;
(
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  byte_in,
    input  logic        keep,
    output logic [15:0] a_out,
    output logic [15:0] b_out
);

    logic [15:0] a_next;
    logic [15:0] b_next;

    always_comb begin
        a_next = mod_sub({1'b0, a_in} + {9'b0, byte_in});
        b_next = mod_sub({1'b0, b_in} + {1'b0, a_next});
        a_out  = keep ? a_next : a_in;
        b_out  = keep ? b_next : b_in;
    end

endmodule

// File: rtl/adler32_stream.sv
// Multi-byte-per-beat Adler-32 engine with input and result handshakes.
//   clock          : rising-edge clock
//   rst            : synchronous active-high reset
//   data           : BYTES input bytes, lane 0 first in stream order
//   data_keep      : per-lane byte valid
//   data_valid     : beat offered
//   data_last      : beat closes the message
//   data_ready     : engine accepts beats (ACCUM)
//   seed_load      : start from seed_in instead of the current sums
//   seed_in        : {B, A} seed
//   checksum_valid : result held (DONE)
//   checksum_ready : consumer takes the result
//   checksum       : {B, A}
//   byte_count     : bytes folded into the current message
module adler32_stream
    import adler_pkg::*;
#(
    parameter int unsigned BYTES = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [8*BYTES-1:0] data,
    input  logic [BYTES-1:0]   data_keep,
    input  logic               data_valid,
    input  logic               data_last,
    output logic               data_ready,
    input  logic               seed_load,
    input  logic [31:0]        seed_in,
    output logic               checksum_valid,
    input  logic               checksum_ready,
    output logic [31:0]        checksum,
    output logic [CNT_W-1:0]   byte_count
);

    state_t            state;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              seed_sel;
    logic              beat_acc;
    logic [15:0]       a_start;
    logic [15:0]       b_start;
    logic [CNT_W-1:0]  keep_cnt;

    logic [15:0]       a_chain [0:BYTES];
    logic [15:0]       b_chain [0:BYTES];

    always_comb begin
        seed_sel = (state == ACCUM) && seed_load;
        beat_acc = data_valid && data_ready;
        // A seed loaded alongside a beat is the starting point of that beat.
        a_start  = seed_sel ? mod_sub({1'b0, seed_in[15:0]})  : a_q;
        b_start  = seed_sel ? mod_sub({1'b0, seed_in[31:16]}) : b_q;
        keep_cnt = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            keep_cnt = keep_cnt + CNT_W'(data_keep[i]);
        end
    end

    assign a_chain[0] = a_start;
    assign b_chain[0] = b_start;

    for (genvar g = 0; g < BYTES; g++) begin : g_lane
        adler_lane_step u_step (
            .a_in    (a_chain[g]),
            .b_in    (b_chain[g]),
            .byte_in (data[8*g +: 8]),
            .keep    (data_keep[g]),
            .a_out   (a_chain[g+1]),
            .b_out   (b_chain[g+1])
        );
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= ACCUM;
            a_q            <= ADLER_INIT[15:0];
            b_q            <= ADLER_INIT[31:16];
            cnt_q          <= '0;
            data_ready     <= 1'b1;
            checksum_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat_acc) begin
                        a_q   <= a_chain[BYTES];
                        b_q   <= b_chain[BYTES];
                        cnt_q <= cnt_q + keep_cnt;
                        if (data_last) begin
                            state          <= DONE;
                            data_ready     <= 1'b0;
                            checksum_valid <= 1'b1;
                        end
                    end else if (seed_sel) begin
                        a_q <= a_start;
                        b_q <= b_start;
                    end
                end
                DONE: begin
                    if (checksum_ready) begin
                        state          <= ACCUM;
                        a_q            <= ADLER_INIT[15:0];
                        b_q            <= ADLER_INIT[31:16];
                        cnt_q          <= '0;
                        data_ready     <= 1'b1;
                        checksum_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign checksum   = {b_q, a_q};
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_adler32_stream.sv
// Self-checking bench for adler32_stream (BYTES=1 and BYTES=4 instances).
module tb_adler32_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst;

    logic [31:0] d4;
    logic [3:0]  k4;
    logic        v4, l4, rdy4, sl4, cv4, cr4;
    logic [31:0] si4, cs4, cnt4;

    logic [7:0]  d1;
    logic        k1, v1, l1, rdy1, sl1, cv1, cr1;
    logic [31:0] si1, cs1, cnt1;

    int checks   = 0;
    int failures = 0;

    typedef logic [7:0] bq_t [$];

    adler32_stream #(.BYTES(4), .CNT_W(32)) dut4 (
        .clock(clock), .rst(rst), .data(d4), .data_keep(k4), .data_valid(v4),
        .data_last(l4), .data_ready(rdy4), .seed_load(sl4), .seed_in(si4),
        .checksum_valid(cv4), .checksum_ready(cr4), .checksum(cs4), .byte_count(cnt4)
    );

    adler32_stream #(.BYTES(1), .CNT_W(32)) dut1 (
        .clock(clock), .rst(rst), .data(d1), .data_keep(k1), .data_valid(v1),
        .data_last(l1), .data_ready(rdy1), .seed_load(sl1), .seed_in(si1),
        .checksum_valid(cv1), .checksum_ready(cr1), .checksum(cs1), .byte_count(cnt1)
    );

    // Reference: textbook Adler-32 over a byte list, starting from a seed.
    function automatic logic [31:0] adler_ref(input logic [31:0] seed, input bq_t q);
        int unsigned a, b;
        a = 32'(seed[15:0]) % 65521;
        b = 32'(seed[31:16]) % 65521;
        foreach (q[i]) begin
            a = (a + 32'(q[i])) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic beat4(input logic [31:0] d, input logic [3:0] k, input logic l,
                         input logic sl, input logic [31:0] si);
        @(negedge clock);
        checks++;
        if (rdy4 !== 1'b1) begin
            failures++;
            $display("FAIL beat_ready got=%b want=1", rdy4);
        end
        d4 = d; k4 = k; l4 = l; v4 = 1'b1; sl4 = sl; si4 = si;
        @(posedge clock); #1;
        v4 = 1'b0; l4 = 1'b0; sl4 = 1'b0;
        d4 = $urandom; k4 = 4'($urandom);
    endtask

    task automatic send_msg4(input bq_t q, input logic sl, input logic [31:0] si, input int max_gap);
        int n = q.size();
        int i = 0;
        logic first = 1'b1;
        logic [31:0] d;
        logic [3:0]  k;
        if (n == 0) beat4($urandom, 4'h0, 1'b1, sl, si);
        while (i < n) begin
            d = $urandom;
            k = 4'h0;
            for (int j = 0; j < 4 && i < n; j++) begin
                d[8*j +: 8] = q[i];
                k[j] = 1'b1;
                i++;
            end
            beat4(d, k, (i >= n), sl && first, si);
            first = 1'b0;
            if (i < n && max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clock);
        end
    endtask

    // Wait for the result, check it (and latency when lat>=0), hold it for
    // 'hold' cycles while pushing a seed that must be ignored, then take it.
    task automatic get4(input logic [31:0] exp_cs, input logic [31:0] exp_cnt,
                        input string name, input int hold, input int lat);
        int w = 0;
        @(negedge clock);
        while (cv4 !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (cv4 !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid_timeout got=%b want=1", name, cv4);
        end
        if (lat >= 0) begin
            checks++;
            if (w != lat) begin
                failures++;
                $display("FAIL %s_latency got=%0d want=%0d", name, w, lat);
            end
        end
        checks++;
        if (cs4 !== exp_cs) begin
            failures++;
            $display("FAIL %s_checksum got=%h want=%h", name, cs4, exp_cs);
        end
        checks++;
        if (cnt4 !== exp_cnt) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d", name, cnt4, exp_cnt);
        end
        repeat (hold) begin
            sl4 = 1'b1; si4 = $urandom;
            @(negedge clock);
            checks++;
            if (cs4 !== exp_cs || cv4 !== 1'b1 || rdy4 !== 1'b0 || cnt4 !== exp_cnt) begin
                failures++;
                $display("FAIL %s_hold got=%h/%b/%b/%0d want=%h/1/0/%0d",
                         name, cs4, cv4, rdy4, cnt4, exp_cs, exp_cnt);
            end
        end
        cr4 = 1'b1;
        @(posedge clock); #1;
        cr4 = 1'b0; sl4 = 1'b0;
        @(negedge clock);
        checks++;
        if (rdy4 !== 1'b1 || cv4 !== 1'b0 || cs4 !== 32'h1 || cnt4 !== 32'h0) begin
            failures++;
            $display("FAIL %s_rearm got=%b/%b/%h/%0d want=1/0/00000001/0",
                     name, rdy4, cv4, cs4, cnt4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        checks++;
        if (rdy4 !== 1'b1 || cv4 !== 1'b0 || cs4 !== 32'h1 || cnt4 !== 32'h0) begin
            failures++;
            $display("FAIL reset4 got=%b/%b/%h/%0d want=1/0/00000001/0", rdy4, cv4, cs4, cnt4);
        end
        checks++;
        if (rdy1 !== 1'b1 || cv1 !== 1'b0 || cs1 !== 32'h1 || cnt1 !== 32'h0) begin
            failures++;
            $display("FAIL reset1 got=%b/%b/%h/%0d want=1/0/00000001/0", rdy1, cv1, cs1, cnt1);
        end
    endtask

    task automatic test_wiki1();
        bq_t q = str2q("Wikipedia");
        foreach (q[i]) begin
            @(negedge clock);
            checks++;
            if (rdy1 !== 1'b1) begin
                failures++;
                $display("FAIL wiki1_ready got=%b want=1", rdy1);
            end
            d1 = q[i]; k1 = 1'b1; v1 = 1'b1; l1 = (i == q.size() - 1);
            @(posedge clock); #1;
            v1 = 1'b0; l1 = 1'b0; d1 = $urandom;
        end
        @(negedge clock);
        checks++;
        if (cv1 !== 1'b1 || cs1 !== 32'h11E60398 || cnt1 !== 32'd9) begin
            failures++;
            $display("FAIL wiki1_result got=%b/%h/%0d want=1/11e60398/9", cv1, cs1, cnt1);
        end
        cr1 = 1'b1;
        @(posedge clock); #1 cr1 = 1'b0;
        @(negedge clock);
        checks++;
        if (cv1 !== 1'b0 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL wiki1_rearm got=%b/%b want=0/1", cv1, rdy1);
        end
    endtask

    task automatic test_wiki4();
        send_msg4(str2q("Wikipedia"), 1'b0, 32'h0, 2);
        get4(32'h11E60398, 32'd9, "wiki4", 0, 0);
        send_msg4(str2q("Wikipedia"), 1'b0, 32'h0, 2);
        get4(32'h11E60398, 32'd9, "wiki4_hold", 5, 0);
    endtask

    task automatic test_empty_back_to_back();
        bq_t e;
        send_msg4(e, 1'b0, 32'h0, 0);
        get4(32'h00000001, 32'd0, "empty", 0, 0);
        send_msg4(str2q("abc"), 1'b0, 32'h0, 0);
        get4(32'h024D0127, 32'd3, "abc", 0, 0);
    endtask

    task automatic test_seed_wrap();
        beat4({24'($urandom), 8'h05}, 4'b0001, 1'b1, 1'b1, 32'hFFF0FFF0);
        get4(32'h00030004, 32'd1, "seed_wrap", 0, 0);
        beat4({24'($urandom), 8'h01}, 4'b0001, 1'b1, 1'b1, 32'h0000FFF0);
        get4(32'h00000000, 32'd1, "seed_zero", 0, 0);
        beat4({24'($urandom), 8'h00}, 4'b0001, 1'b1, 1'b1, 32'hFFFFFFFF);
        get4(adler_ref(32'hFFFFFFFF, '{8'h00}), 32'd1, "seed_reduce", 0, 0);
    endtask

    task automatic test_reset_mid();
        beat4({"i", "k", "i", "W"}, 4'hF, 1'b0, 1'b0, 32'h0);
        @(negedge clock) rst = 1'b1;
        @(posedge clock); #1 rst = 1'b0;
        send_msg4(str2q("abc"), 1'b0, 32'h0, 0);
        get4(32'h024D0127, 32'd3, "reset_mid", 0, 0);
        send_msg4(str2q("ab"), 1'b0, 32'h0, 0);
        @(negedge clock);
        checks++;
        if (cv4 !== 1'b1) begin
            failures++;
            $display("FAIL done_before_reset got=%b want=1", cv4);
        end
        rst = 1'b1;
        @(posedge clock); #1 rst = 1'b0;
        @(negedge clock);
        checks++;
        if (cv4 !== 1'b0 || rdy4 !== 1'b1 || cs4 !== 32'h1 || cnt4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_done got=%b/%b/%h/%0d want=0/1/00000001/0", cv4, rdy4, cs4, cnt4);
        end
    endtask

    task automatic test_noncontig();
        beat4({"Y", "b", "X", "a"}, 4'b0101, 1'b1, 1'b0, 32'h0);
        get4(32'h012600C4, 32'd2, "noncontig", 0, 0);
    endtask

    task automatic test_random();
        for (int m = 0; m < 25; m++) begin
            bq_t q;
            int nb = $urandom_range(5, 1);
            logic sl = 1'($urandom);
            logic [31:0] si = $urandom;
            logic [31:0] d;
            logic [3:0]  k;
            for (int b = 0; b < nb; b++) begin
                d = $urandom;
                k = 4'($urandom);
                for (int j = 0; j < 4; j++) if (k[j]) q.push_back(d[8*j +: 8]);
                beat4(d, k, (b == nb - 1), sl && (b == 0), si);
                if (b != nb - 1) repeat ($urandom_range(2, 0)) @(negedge clock);
            end
            get4(adler_ref(sl ? si : 32'h1, q), 32'(q.size()), "random",
                 $urandom_range(2, 0), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        d4 = '0; k4 = '0; v4 = 1'b0; l4 = 1'b0; sl4 = 1'b0; si4 = '0; cr4 = 1'b0;
        d1 = '0; k1 = 1'b0; v1 = 1'b0; l1 = 1'b0; sl1 = 1'b0; si1 = '0; cr1 = 1'b0;
        test_reset();
        test_wiki1();
        test_wiki4();
        test_empty_back_to_back();
        test_seed_wrap();
        test_reset_mid();
        test_noncontig();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
